// File: rtl/mem_io_responder_if.sv
// CPU byte-wide memory bus between the cpu (master) and mem_io_responder (slave).
//   mem_a          byte address (bits 17:0 decoded by the responder)
//   mem_dout       write data from CPU
//   mem_wr         1 = write, 0 = read
//   mem_din        registered read data to CPU
//   io_buffer_full transmit FIFO near full, lets the CPU throttle UART writes
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;

  modport master (output mem_a, mem_dout, mem_wr, input  mem_din, io_buffer_full);
  modport slave  (input  mem_a, mem_dout, mem_wr, output mem_din, io_buffer_full);
endinterface

// File: rtl/mem_io_responder.sv
// mem_io_responder: responder end of the CPU byte bus. Holds the 2^ADDR_WIDTH
// byte main RAM and the I/O window at mem_a[17:16] == 2'b11:
//   0x30000 rd : pop host rx byte (0x00 when none), rx_ready pulses with the data
//   0x30000 wr : push non-zero byte to the TX FIFO
//   0x30004 wr : set sticky prog_stop and push 0x00 to the TX FIFO
//   0x30004..7 rd : cycle counter bytes, little-endian
// Ports:
//   clk_in, rst_in (async, active low)
//   bus      : mem_io_responder_if.slave (mem_a/mem_dout/mem_wr in, mem_din/io_buffer_full out)
//   tx_data/tx_valid/tx_ready : TX FIFO head, valid/ready handshake
//   rx_data/rx_valid/rx_ready : host input byte, one-cycle pop strobe
//   prog_stop: sticky program-stop flag
// Optional: define MEMIO_CYCLE_SNAPSHOT_EN to latch the counter on a 0x30004
// read so that a 4-byte load of 0x30004..7 sees one coherent value.
module mem_io_responder #(
  parameter int ADDR_WIDTH    = 17,
  parameter int TXQ_DEPTH_LOG = 3,
  parameter int FULL_MARGIN   = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  mem_io_responder_if.slave    bus,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 prog_stop
);
  localparam int CNT_W = TXQ_DEPTH_LOG + 1;
  localparam logic [CNT_W-1:0] DEPTH   = CNT_W'(1 << TXQ_DEPTH_LOG);
  localparam logic [CNT_W-1:0] FULL_TH = CNT_W'((1 << TXQ_DEPTH_LOG) - FULL_MARGIN);

  // ---------------- decode ----------------
  logic                  io_sel;
  logic [15:0]           io_off;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  unused_addr_hi;

  assign io_sel         = (bus.mem_a[17:16] == 2'b11);
  assign io_off         = bus.mem_a[15:0];
  assign ram_addr       = bus.mem_a[ADDR_WIDTH-1:0];
  assign unused_addr_hi = ^bus.mem_a[31:18];

  // ---------------- RAM (not reset) ----------------
  logic [7:0] ram [0:(1<<ADDR_WIDTH)-1];
  logic [7:0] ram_rd_q;

  always_ff @(posedge clk_in) begin
    if (!io_sel && bus.mem_wr) ram[ram_addr] <= bus.mem_dout;
    ram_rd_q <= ram[ram_addr];
  end

  // ---------------- TX FIFO storage (not reset) ----------------
  logic [7:0]               txq [0:(1<<TXQ_DEPTH_LOG)-1];
  logic [TXQ_DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     full_q, full_d;
  logic                     push_req, push, pop;
  logic [7:0]               push_byte;

  always_ff @(posedge clk_in) begin
    if (push) txq[wr_ptr_q] <= push_byte;
  end

  // ---------------- control / IO state ----------------
  logic        rd_ram_q, rd_ram_d;   // mem_din source select: RAM vs IO byte
  logic [7:0]  io_rd_q, io_rd_d;
  logic        rx_pop_q, rx_pop_d;
  logic        stop_q, stop_d;
  logic [31:0] cyc_q, cyc_d;
`ifdef MEMIO_CYCLE_SNAPSHOT_EN
  logic [31:0] snap_q, snap_d;
`endif

  always_comb begin
    rd_ram_d = !io_sel && !bus.mem_wr;
    io_rd_d  = 8'h00;
    rx_pop_d = 1'b0;
    cyc_d    = cyc_q + 32'd1;
`ifdef MEMIO_CYCLE_SNAPSHOT_EN
    snap_d   = snap_q;
`endif
    if (io_sel && !bus.mem_wr) begin
      if (io_off == 16'h0000) begin
        if (rx_valid) begin
          io_rd_d  = rx_data;
          rx_pop_d = 1'b1;
        end
      end else if (io_off[15:2] == 14'd1) begin
`ifdef MEMIO_CYCLE_SNAPSHOT_EN
        // byte 0 latches the live counter; bytes 1..3 replay the latched copy
        if (io_off[1:0] == 2'b00) begin
          snap_d  = cyc_q;
          io_rd_d = cyc_q[7:0];
        end else begin
          io_rd_d = snap_q[{io_off[1:0], 3'b000} +: 8];
        end
`else
        io_rd_d = cyc_q[{io_off[1:0], 3'b000} +: 8];
`endif
      end
    end
  end

  // TX push/pop and the sticky stop flag
  always_comb begin
    push_req  = 1'b0;
    push_byte = bus.mem_dout;
    stop_d    = stop_q;
    if (io_sel && bus.mem_wr && !stop_q) begin
      if (io_off == 16'h0000) begin
        push_req = (bus.mem_dout != 8'h00);
      end else if (io_off == 16'h0004) begin
        push_req  = 1'b1;
        push_byte = 8'h00;
        stop_d    = 1'b1;
      end
    end
    pop      = (cnt_q != '0) && tx_ready;
    // a full FIFO still takes a push when the head leaves in the same cycle
    push     = push_req && ((cnt_q != DEPTH) || pop);
    wr_ptr_d = wr_ptr_q + TXQ_DEPTH_LOG'(push);
    rd_ptr_d = rd_ptr_q + TXQ_DEPTH_LOG'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    // flag ahead of true full so the CPU has a cycle to react
    full_d   = (cnt_d >= FULL_TH);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_ram_q <= 1'b0;
      io_rd_q  <= 8'h00;
      rx_pop_q <= 1'b0;
      stop_q   <= 1'b0;
      cyc_q    <= 32'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
`ifdef MEMIO_CYCLE_SNAPSHOT_EN
      snap_q   <= 32'd0;
`endif
    end else begin
      rd_ram_q <= rd_ram_d;
      io_rd_q  <= io_rd_d;
      rx_pop_q <= rx_pop_d;
      stop_q   <= stop_d;
      cyc_q    <= cyc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
`ifdef MEMIO_CYCLE_SNAPSHOT_EN
      snap_q   <= snap_d;
`endif
    end
  end

  assign bus.mem_din        = rd_ram_q ? ram_rd_q : io_rd_q;
  assign bus.io_buffer_full = full_q;
  assign tx_valid           = (cnt_q != '0);
  assign tx_data            = txq[rd_ptr_q];
  assign rx_ready           = rx_pop_q;
  assign prog_stop          = stop_q;
endmodule
